// File: rtl/frame_draw_scheduler.sv
// Per-frame scan sequencer: walks the grid through the frame tracker and issues
// req/ack draw commands for cells that need repainting.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for frame_start
// ADDR  | x/y presented to tracker, waiting TRACK_LAT cycles
// EVAL  | tracker outputs valid; decide whether the cell is drawn
// REQ   | draw command held until draw_ack
// NEXT  | advance to next cell in row-major order, or finish
// DONE  | one-cycle frame_done, publish draw_count
module frame_draw_scheduler #(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int TRACK_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       force_full,
    input  logic [2:0] obj_code,
    input  logic       diff,
    input  logic       draw_ack,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       track_en,
    output logic       draw_req,
    output logic [3:0] draw_x,
    output logic [3:0] draw_y,
    output logic [2:0] draw_code,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] draw_count
);

    localparam int LAT_W = (TRACK_LAT > 1) ? $clog2(TRACK_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(TRACK_LAT - 1);
    localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_EVAL,
        S_REQ,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LAT_W-1:0] lat_cnt;
    logic             full_mode;
    logic             full_pending;
    logic [7:0]       run_cnt;
    logic             x_last;
    logic             y_last;
    logic             cell_draw;

    assign x_last    = (x == X_MAX);
    assign y_last    = (y == Y_MAX);
    assign cell_draw = diff | full_mode;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (lat_cnt == '0) state_nxt = S_EVAL;
            end
            S_EVAL: begin
                state_nxt = cell_draw ? S_REQ : S_NEXT;
            end
            S_REQ: begin
                if (draw_ack) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                state_nxt = (x_last && y_last) ? S_DONE : S_ADDR;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            x            <= '0;
            y            <= '0;
            track_en     <= 1'b0;
            draw_req     <= 1'b0;
            draw_x       <= '0;
            draw_y       <= '0;
            draw_code    <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            draw_count   <= '0;
            lat_cnt      <= '0;
            full_mode    <= 1'b0;
            full_pending <= 1'b1;
            run_cnt      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        x            <= '0;
                        y            <= '0;
                        full_mode    <= force_full | full_pending;
                        full_pending <= 1'b0;
                        run_cnt      <= '0;
                        busy         <= 1'b1;
                        track_en     <= 1'b1;
                        lat_cnt      <= LAT_LOAD;
                    end
                end
                S_ADDR: begin
                    if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
                end
                S_EVAL: begin
                    if (cell_draw) begin
                        draw_x    <= x;
                        draw_y    <= y;
                        draw_code <= obj_code;
                        draw_req  <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (draw_ack) begin
                        draw_req <= 1'b0;
                        if (run_cnt != 8'hFF) run_cnt <= run_cnt + 8'd1;
                    end
                end
                S_NEXT: begin
                    lat_cnt <= LAT_LOAD;
                    if (x_last && y_last) begin
                        frame_done <= 1'b1;
                    end else if (x_last) begin
                        x <= '0;
                        y <= y + 4'd1;
                    end else begin
                        x <= x + 4'd1;
                    end
                end
                S_DONE: begin
                    // x/y deliberately hold the last cell
                    frame_done <= 1'b0;
                    draw_count <= run_cnt;
                    busy       <= 1'b0;
                    track_en   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench for frame_draw_scheduler: tracker model, ack driver and
// draw recorder around a linear sequence of scan scenarios.
module tb_frame_draw_scheduler;

    logic       tb_clk;
    logic       rst;
    logic       frame_start;
    logic       force_full;
    logic [2:0] obj_code;
    logic       diff;
    logic       draw_ack = 1'b1;
    logic [3:0] x;
    logic [3:0] y;
    logic       track_en;
    logic       draw_req;
    logic [3:0] draw_x;
    logic [3:0] draw_y;
    logic [2:0] draw_code;
    logic       busy;
    logic       frame_done;
    logic [7:0] draw_count;

    frame_draw_scheduler dut (
        .clk        (tb_clk),
        .rst        (rst),
        .frame_start(frame_start),
        .force_full (force_full),
        .obj_code   (obj_code),
        .diff       (diff),
        .draw_ack   (draw_ack),
        .x          (x),
        .y          (y),
        .track_en   (track_en),
        .draw_req   (draw_req),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .draw_code  (draw_code),
        .busy       (busy),
        .frame_done (frame_done),
        .draw_count (draw_count)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int start_cyc  = 0;
    int lat        = 0;

    always @(posedge tb_clk) cyc <= cyc + 1;

    // tracker model: diff only at the target cell, code derived from position
    logic       diff_en = 1'b0;
    logic [3:0] tx = 4'd0;
    logic [3:0] ty = 4'd0;

    function automatic logic [2:0] code_of(input logic [3:0] cx, input logic [3:0] cy);
        int s;
        s = (int'(cx) + int'(cy) + 2) % 5;
        return 3'(s);
    endfunction

    always_comb begin
        obj_code = code_of(x, y);
        diff     = diff_en && (x == tx) && (y == ty);
    end

    typedef struct {
        logic [3:0] dx;
        logic [3:0] dy;
        logic [2:0] dc;
        int         len;
    } rec_t;

    rec_t       recs[$];
    int         ack_mode   = 0;
    int         req_cycles = 0;
    int         cur_len    = 0;
    int         stable_err = 0;
    int         done_cnt   = 0;
    logic       in_req     = 1'b0;
    logic [3:0] hold_x;
    logic [3:0] hold_y;
    logic [2:0] hold_c;

    // ack driver and draw recorder share one process so ordering is fixed
    always @(negedge tb_clk) begin
        case (ack_mode)
            0: draw_ack = 1'b1;
            1: begin
                if (draw_req) begin
                    draw_ack = (req_cycles == 7);
                    req_cycles++;
                end else begin
                    draw_ack   = 1'b0;
                    req_cycles = 0;
                end
            end
            default: draw_ack = 1'b0;
        endcase
        if (draw_req) begin
            if (!in_req) begin
                hold_x  = draw_x;
                hold_y  = draw_y;
                hold_c  = draw_code;
                in_req  = 1'b1;
                cur_len = 0;
            end else if (draw_x !== hold_x || draw_y !== hold_y || draw_code !== hold_c) begin
                stable_err++;
            end
            if (x !== hold_x || y !== hold_y) stable_err++;
            cur_len++;
            if (draw_ack) begin
                recs.push_back('{dx: draw_x, dy: draw_y, dc: draw_code, len: cur_len});
                in_req = 1'b0;
            end
        end else begin
            in_req = 1'b0;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        recs.delete();
        stable_err = 0;
        done_cnt   = 0;
    endtask

    task automatic start_frame(input logic ff);
        @(posedge tb_clk);
        #1 frame_start = 1'b1;
        force_full = ff;
        @(posedge tb_clk);
        #1 start_cyc = cyc;
        frame_start = 1'b0;
        force_full  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int l);
        int n;
        n = 0;
        do begin
            @(negedge tb_clk);
            n++;
        end while (frame_done !== 1'b1 && n < budget);
        if (frame_done !== 1'b1) chk("frame_done_timeout", 32'(frame_done), 1);
        l = cyc - start_cyc;
    endtask

    initial begin
        int order_err;
        rst         = 1'b1;
        frame_start = 1'b0;
        force_full  = 1'b0;
        repeat (3) @(posedge tb_clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_busy", busy, 0);
        chk("rst_track_en", track_en, 0);
        chk("rst_draw_req", draw_req, 0);
        chk("rst_draw_count", draw_count, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;

        // first frame after reset redraws everything even with diff low
        clear_stats();
        start_frame(1'b0);
        chk("f1_busy", busy, 1);
        chk("f1_track_en", track_en, 1);
        wait_done(2000, lat);
        chk("f1_latency", lat, 768);
        @(posedge tb_clk);
        #1;
        chk("f1_draw_count", draw_count, 192);
        chk("f1_busy_after", busy, 0);
        chk("f1_track_en_after", track_en, 0);
        chk("f1_draws", recs.size(), 192);
        chk("f1_done_pulses", done_cnt, 1);

        // second frame, nothing changed
        clear_stats();
        start_frame(1'b0);
        wait_done(2000, lat);
        chk("f2_latency", lat, 576);
        @(posedge tb_clk);
        #1;
        chk("f2_draw_count", draw_count, 0);
        chk("f2_draws", recs.size(), 0);

        // single changed cell at (4,5), tied ack
        diff_en = 1'b1;
        tx = 4'd4;
        ty = 4'd5;
        clear_stats();
        start_frame(1'b0);
        wait_done(2000, lat);
        chk("one_latency", lat, 577);
        @(posedge tb_clk);
        #1;
        chk("one_draws", recs.size(), 1);
        if (recs.size() > 0) begin
            chk("one_draw_x", recs[0].dx, 4);
            chk("one_draw_y", recs[0].dy, 5);
            chk("one_draw_code", recs[0].dc, 1);
            chk("one_req_len", recs[0].len, 1);
        end
        chk("one_draw_count", draw_count, 1);

        // same cell, ack withheld for 7 cycles
        ack_mode = 1;
        clear_stats();
        start_frame(1'b0);
        wait_done(2000, lat);
        chk("slow_latency", lat, 584);
        @(posedge tb_clk);
        #1;
        chk("slow_draws", recs.size(), 1);
        if (recs.size() > 0) begin
            chk("slow_req_len", recs[0].len, 8);
            chk("slow_draw_x", recs[0].dx, 4);
            chk("slow_draw_y", recs[0].dy, 5);
        end
        chk("slow_stable", stable_err, 0);
        chk("slow_draw_count", draw_count, 1);
        ack_mode = 0;

        // forced full redraw, check row-major order and codes
        diff_en = 1'b0;
        clear_stats();
        start_frame(1'b1);
        wait_done(2000, lat);
        chk("full_latency", lat, 768);
        @(posedge tb_clk);
        #1;
        chk("full_draws", recs.size(), 192);
        order_err = 0;
        for (int i = 0; i < recs.size(); i++) begin
            if (recs[i].dx !== 4'(i % 16) || recs[i].dy !== 4'(i / 16) ||
                recs[i].dc !== code_of(4'(i % 16), 4'(i / 16)))
                order_err++;
        end
        chk("full_order", order_err, 0);
        if (recs.size() > 0) begin
            chk("full_last_x", recs[recs.size()-1].dx, 15);
            chk("full_last_y", recs[recs.size()-1].dy, 11);
        end
        chk("full_draw_count", draw_count, 192);

        // frame_start pulses while busy are ignored
        clear_stats();
        start_frame(1'b0);
        repeat (50) @(posedge tb_clk);
        #1 frame_start = 1'b1;
        @(posedge tb_clk);
        #1 frame_start = 1'b0;
        repeat (200) @(posedge tb_clk);
        #1 frame_start = 1'b1;
        force_full = 1'b1;
        @(posedge tb_clk);
        #1 frame_start = 1'b0;
        force_full = 1'b0;
        wait_done(2000, lat);
        chk("busy_ign_latency", lat, 576);
        @(posedge tb_clk);
        #1;
        chk("busy_ign_x_hold", x, 15);
        chk("busy_ign_y_hold", y, 11);
        chk("busy_ign_draws", recs.size(), 0);
        repeat (20) @(posedge tb_clk);
        #1;
        chk("busy_ign_done_pulses", done_cnt, 1);
        chk("busy_ign_idle", busy, 0);
        start_frame(1'b0);
        chk("restart_x", x, 0);
        chk("restart_y", y, 0);
        chk("restart_busy", busy, 1);
        wait_done(2000, lat);
        chk("restart_latency", lat, 576);

        // reset while a draw is pending at (7,3)
        diff_en  = 1'b1;
        tx       = 4'd7;
        ty       = 4'd3;
        ack_mode = 2;
        @(posedge tb_clk);
        #1 clear_stats();
        start_frame(1'b0);
        begin
            int n;
            n = 0;
            do begin
                @(negedge tb_clk);
                n++;
            end while (draw_req !== 1'b1 && n < 1000);
        end
        chk("rst_mid_req", draw_req, 1);
        chk("rst_mid_draw_x", draw_x, 7);
        chk("rst_mid_draw_y", draw_y, 3);
        @(posedge tb_clk);
        #1 rst = 1'b1;
        @(posedge tb_clk);
        #1;
        chk("rst_mid_draw_req", draw_req, 0);
        chk("rst_mid_x", x, 0);
        chk("rst_mid_y", y, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_track_en", track_en, 0);
        chk("rst_mid_draw_xo", draw_x, 0);
        chk("rst_mid_draw_yo", draw_y, 0);
        chk("rst_mid_draw_code", draw_code, 0);
        chk("rst_mid_draw_count", draw_count, 0);
        rst = 1'b0;
        ack_mode = 0;
        diff_en  = 1'b0;
        repeat (10) @(posedge tb_clk);
        #1;
        chk("rst_mid_no_done", done_cnt, 0);
        chk("rst_mid_frame_done", frame_done, 0);
        clear_stats();
        start_frame(1'b0);
        wait_done(2000, lat);
        chk("post_rst_latency", lat, 768);
        @(posedge tb_clk);
        #1;
        chk("post_rst_draw_count", draw_count, 192);
        chk("post_rst_done_pulses", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
